// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and the operand-conditioning
// decode used by the adder datapath.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  typedef struct packed {
    logic invert_b;
    logic carry_in;
  } op_ctrl_t;

  // Subtraction is A + ~B + 1; the borrow-chained forms take the caller's carry.
  function automatic op_ctrl_t op_decode(op_e op, logic cin);
    op_ctrl_t ctrl;
    ctrl = '0;
    unique case (op)
      OP_ADD: ctrl = '{invert_b: 1'b0, carry_in: 1'b0};
      OP_SUB: ctrl = '{invert_b: 1'b1, carry_in: 1'b1};
      OP_ADC: ctrl = '{invert_b: 1'b0, carry_in: cin};
      OP_SBC: ctrl = '{invert_b: 1'b1, carry_in: cin};
      default: ctrl = '0;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Valid/ready operand and result channels of the pipelined adder.
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_op, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );
endinterface

// File: rtl/adder_slice.sv
// One pipeline stage: adds slice IDX of the operands with the carry from the
// previous stage and registers the whole beat (operands, partial sum, flags).
module adder_slice #(
  parameter int WIDTH = 32,
  parameter int SW    = 16,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             valid_in,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] sum_in,
  output logic             valid_q,
  output logic             carry_q,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] sum_q,
  output logic             zero_q,
  output logic             ovf_q
);
  localparam int LO = IDX * SW;

  logic [SW:0]      slice_sum;
  logic [WIDTH-1:0] sum_next;

  always_comb begin
    slice_sum = {1'b0, a_in[LO +: SW]} + {1'b0, b_in[LO +: SW]} + {{SW{1'b0}}, carry_in};
    sum_next  = sum_in;
    sum_next[LO +: SW] = slice_sum[SW-1:0];
  end

  // Flags are only meaningful in the last stage, where sum_next is complete.
  // NOTE: every state register uses <= so all stages sample the pre-edge
  // values of their neighbours; blocking here would collapse the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are reset too, because the output
      // port values after reset are architecturally visible (all zero).
      valid_q <= 1'b0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (en) begin
      valid_q <= valid_in;
      carry_q <= slice_sum[SW];
      a_q     <= a_in;
      b_q     <= b_in;
      sum_q   <= sum_next;
      zero_q  <= (sum_next == '0);
      ovf_q   <= (a_in[WIDTH-1] == b_in[WIDTH-1]) && (sum_next[WIDTH-1] != a_in[WIDTH-1]);
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// Add/subtract unit split into STAGES carry-registered slices with a single
// global stall: the whole pipe advances only when the result can move on.
module pipelined_adder
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  pipelined_adder_if.slave  bus
);
  localparam int SW = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > 4 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_adder: STAGES must be 1..4 and divide WIDTH");
  end

  logic             advance;
  op_ctrl_t         ctrl;
  logic [WIDTH-1:0] b_eff;

  logic [STAGES:0]  valid_s;
  logic [STAGES:0]  carry_s;
  logic [STAGES:1]  zero_s;
  logic [STAGES:1]  ovf_s;
  logic [WIDTH-1:0] a_s   [STAGES+1];
  logic [WIDTH-1:0] b_s   [STAGES+1];
  logic [WIDTH-1:0] sum_s [STAGES+1];

  // NOTE: always_comb assigns every output first so no path can infer a latch.
  always_comb begin
    ctrl  = op_decode(op_e'(bus.in_op), bus.in_cin);
    b_eff = ctrl.invert_b ? ~bus.in_b : bus.in_b;
  end

  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  assign valid_s[0] = bus.in_valid;
  assign carry_s[0] = ctrl.carry_in;
  assign a_s[0]     = bus.in_a;
  assign b_s[0]     = b_eff;
  assign sum_s[0]   = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_slice #(
      .WIDTH (WIDTH),
      .SW    (SW),
      .IDX   (k)
    ) u_slice (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (advance),
      .valid_in (valid_s[k]),
      .carry_in (carry_s[k]),
      .a_in     (a_s[k]),
      .b_in     (b_s[k]),
      .sum_in   (sum_s[k]),
      .valid_q  (valid_s[k+1]),
      .carry_q  (carry_s[k+1]),
      .a_q      (a_s[k+1]),
      .b_q      (b_s[k+1]),
      .sum_q    (sum_s[k+1]),
      .zero_q   (zero_s[k+1]),
      .ovf_q    (ovf_s[k+1])
    );
  end

  assign bus.out_valid = valid_s[STAGES];
  assign bus.out_sum   = sum_s[STAGES];
  assign bus.out_cout  = carry_s[STAGES];
  assign bus.out_ovf   = ovf_s[STAGES];
  assign bus.out_zero  = zero_s[STAGES];

endmodule
